dot_product_engine: RTL



---
 rtl/dot_product_engine.sv | 117 +++++++++++
 1 files changed

// File: rtl/dot_product_engine.sv
// dot_product_engine: byte-loaded dot product with 2-stage pipeline, wide accumulator and chunked streaming output
module dot_product_engine #(
  parameter int DW       = 8,
  parameter int LANES    = 4,
  parameter int ACC_BITS = 4,
  parameter int OUT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DW-1:0]    in_data,
  input  logic             in_valid,
  input  logic             in_sel,
  output logic             in_ready,
  input  logic             start,
  input  logic             signed_mode,
  input  logic             acc_mode,
  input  logic             clear_acc,
  output logic             busy,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             done
);
  localparam int PW  = 2*DW + $clog2(LANES);
  localparam int AW  = PW + ACC_BITS;
  localparam int NCH = (AW + OUT_W - 1) / OUT_W;
  localparam int XW  = NCH * OUT_W;
  localparam int IW  = NCH > 1 ? $clog2(NCH) : 1;
  typedef enum logic [1:0] {IDLE, MUL, SUM, OUT} state_e;
  state_e          state_q, state_d;
  logic [DW-1:0]   data_q [LANES];
  logic [DW-1:0]   wt_q   [LANES];
  logic [PW-1:0]   prod_q [LANES];
  logic [PW-1:0]   prod_d [LANES];
  logic [AW-1:0]   acc_q, acc_d, sum;
  logic [IW-1:0]   idx_q, idx_d;
  logic            sgn_q, accm_q, done_q;
  logic [XW-1:0]   acc_x;
  logic            load, hs;
  assign in_ready  = (state_q == IDLE) & ~start & ~rst;
  assign load      = in_valid & in_ready;
  assign busy      = state_q != IDLE;
  assign out_valid = state_q == OUT;
  assign out_last  = out_valid & (idx_q == IW'(NCH-1));
  assign hs        = out_valid & out_ready;
  assign acc_x     = sgn_q ? XW'($signed(acc_q)) : XW'(acc_q);
  assign out_data  = out_valid ? acc_x[idx_q*OUT_W +: OUT_W] : '0;
  assign done      = done_q;
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic signed [2*DW-1:0] ps;
    logic        [2*DW-1:0] pu;
    assign ps        = $signed(data_q[i]) * $signed(wt_q[i]);
    assign pu        = data_q[i] * wt_q[i];
    assign prod_d[i] = sgn_q ? PW'(ps) : PW'(pu);
  end
  always_comb begin
    sum = '0;
    for (int i = 0; i < LANES; i++)
      sum = sum + (sgn_q ? AW'($signed(prod_q[i])) : AW'(prod_q[i]));
  end
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        state_d = start ? MUL : IDLE;
        acc_d   = (clear_acc & ~start) ? '0 : acc_q;
      end
      MUL: state_d = SUM;
      SUM: begin
        state_d = OUT;
        acc_d   = accm_q ? acc_q + sum : sum;
      end
      default: begin
        state_d = (hs & out_last) ? IDLE : OUT;
        idx_d   = hs ? (out_last ? '0 : idx_q + 1'b1) : idx_q;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      idx_q   <= '0;
      sgn_q   <= 1'b0;
      accm_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        data_q[i] <= '0;
        wt_q[i]   <= '0;
        prod_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      done_q  <= hs & out_last;
      if (state_q == IDLE && start) begin
        sgn_q  <= signed_mode;
        accm_q <= acc_mode;
      end
      if (state_q == MUL)
        for (int i = 0; i < LANES; i++) prod_q[i] <= prod_d[i];
      // newest element enters lane 0, oldest falls off the top
      if (load && !in_sel) begin
        for (int i = LANES-1; i > 0; i--) data_q[i] <= data_q[i-1];
        data_q[0] <= in_data;
      end
      if (load && in_sel) begin
        for (int i = LANES-1; i > 0; i--) wt_q[i] <= wt_q[i-1];
        wt_q[0] <= in_data;
      end
    end
  end
endmodule
